// File: rtl/div_share_ctrl.sv
// Shares one iterative divider between the EX issue lanes, serialising requests oldest-lane first.
// Optional DIV_ZERO_BYPASS_EN answers zero-divisor requests locally without starting the divider.
module div_share_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                hold,
    input  logic [LANES-1:0]                    req_valid,
    input  logic [LANES-1:0]                    req_signed,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    req_a,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    req_b,
    output logic [LANES-1:0]                    lane_stall_req,
    output logic [LANES-1:0]                    res_valid,
    output logic [LANES-1:0][DATA_WIDTH-1:0]    res_quot,
    output logic [LANES-1:0][DATA_WIDTH-1:0]    res_rem,
    output logic                                div_start,
    output logic                                div_signed,
    output logic [DATA_WIDTH-1:0]               div_a,
    output logic [DATA_WIDTH-1:0]               div_b,
    output logic                                div_abort,
    input  logic                                div_done,
    input  logic [DATA_WIDTH-1:0]               div_quot,
    input  logic [DATA_WIDTH-1:0]               div_rem
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                             state;
    logic [LW-1:0]                      cur;
    logic [LANES-1:0]                   done;
    logic [LANES-1:0][DATA_WIDTH-1:0]   quot_buf;
    logic [LANES-1:0][DATA_WIDTH-1:0]   rem_buf;

    logic [LANES-1:0]                   pend;
    logic                               sel_found;
    logic [LW-1:0]                      sel;
    logic                               advance;
    logic                               bypass;

    assign pend           = req_valid & ~done;
    assign lane_stall_req = pend;
    assign res_valid      = done;
    assign res_quot       = quot_buf;
    assign res_rem        = rem_buf;
    assign advance        = ~hold & ~|pend;

    // A divide finishing in the flush cycle needs no cancel; reset clears the divider itself.
    assign div_abort = flush & ~rst & (state != IDLE) & ~div_done;

    // Scan downward so the oldest (lowest-numbered) pending lane wins.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        for (int unsigned i = LANES; i > 0; i--) begin
            if (pend[i-1]) begin
                sel_found = 1'b1;
                sel       = LW'(i - 1);
            end
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass = (req_b[sel] == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            done       <= '0;
            quot_buf   <= '0;
            rem_buf    <= '0;
            div_start  <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
        end else begin
            div_start <= 1'b0;
            if (flush) begin
                done  <= '0;
                state <= IDLE;
            end else begin
                if (advance) begin
                    done <= '0;
                end
                case (state)
                    IDLE: begin
                        if (sel_found) begin
                            if (bypass) begin
                                done[sel]     <= 1'b1;
                                quot_buf[sel] <= '1;
                                rem_buf[sel]  <= req_a[sel];
                            end else begin
                                div_signed <= req_signed[sel];
                                div_a      <= req_a[sel];
                                div_b      <= req_b[sel];
                                cur        <= sel;
                                div_start  <= 1'b1;
                                state      <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (div_done) begin
                            // A lane whose request vanished mid-flight gets no result.
                            if (req_valid[cur]) begin
                                done[cur]     <= 1'b1;
                                quot_buf[cur] <= div_quot;
                                rem_buf[cur]  <= div_rem;
                            end
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
